// File: rtl/reg_bus_pkg.sv
// Shared opcode and state types for the register bus adapter.
package reg_bus_pkg;

  // Request-channel opcodes accepted by the adapter.
  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } a_op_e;

  // Response-channel opcodes.
  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } d_op_e;

  // Adapter state: idle, or holding a response on the d channel.
  typedef enum logic {
    StIdle = 1'b0,
    StResp = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bus_err.sv
// Combinational request legality checker: opcode, word alignment and byte mask.
module reg_bus_err
  import reg_bus_pkg::*;
#(
  parameter int unsigned MW = 4
) (
  input  logic [2:0]    opcode,
  input  logic [1:0]    addr_lo,
  input  logic [MW-1:0] mask,
  output logic          req_err
);

  logic is_put;
  logic bad_op;

  // Flag any request the register file must never see.
  always_comb begin
    is_put  = (opcode == PutFullData) || (opcode == PutPartialData);
    bad_op  = !(is_put || (opcode == Get));
    req_err = (addr_lo != 2'b00)
            | bad_op
            | ((opcode == PutFullData) && (mask != '1))
            | (is_put && (mask == '0));
  end

endmodule

// File: rtl/reg_bus_adapter.sv
// Single-outstanding valid/ready bus to register-file strobe adapter.
// DW is expected to be 32: the register space is word-only.
module reg_bus_adapter
  import reg_bus_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32,
  parameter int unsigned SW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            a_valid_i,
  output logic            a_ready_o,
  input  logic [2:0]      a_opcode_i,
  input  logic [AW-1:0]   a_address_i,
  input  logic [DW-1:0]   a_data_i,
  input  logic [DW/8-1:0] a_mask_i,
  input  logic [SW-1:0]   a_source_i,
  output logic            d_valid_o,
  input  logic            d_ready_i,
  output logic [2:0]      d_opcode_o,
  output logic [DW-1:0]   d_data_o,
  output logic [SW-1:0]   d_source_o,
  output logic            d_error_o,
  output logic            re_o,
  output logic            we_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] be_o,
  input  logic [DW-1:0]   rdata_i,
  input  logic            error_i
);

  state_e state_q, state_d;

  logic          req_err;
  logic          accept;
  logic          is_get;
  logic          is_put;
  logic          resp_err;
  logic [2:0]    resp_opcode;
  logic [DW-1:0] resp_data;

  reg_bus_err #(
    .MW (DW/8)
  ) u_err (
    .opcode  (a_opcode_i),
    .addr_lo (a_address_i[1:0]),
    .mask    (a_mask_i),
    .req_err (req_err)
  );

  // Ready comes only from registered state, so a handshaking response never
  // overlaps a new accept.
  always_comb begin
    a_ready_o = (state_q == StIdle);
    d_valid_o = (state_q == StResp);
    accept    = a_valid_i & a_ready_o;
  end

  // Decode the request and build the strobes and the response to capture.
  always_comb begin
    is_get      = (a_opcode_i == Get);
    is_put      = (a_opcode_i == PutFullData) || (a_opcode_i == PutPartialData);
    re_o        = accept & ~req_err & is_get;
    we_o        = accept & ~req_err & is_put;
    addr_o      = {a_address_i[AW-1:2], 2'b00};
    wdata_o     = a_data_i;
    be_o        = a_mask_i;
    resp_err    = req_err | error_i;
    resp_opcode = is_get ? AccessAckData : AccessAck;
    if (is_get) begin
      resp_data = resp_err ? '1 : rdata_i;
    end else begin
      resp_data = '0;
    end
  end

  // Next-state logic: accept moves to RESP, the d handshake returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StResp;
      StResp:  if (d_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Response registers: loaded on accept, held stable until the next accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_opcode_o <= '0;
      d_data_o   <= '0;
      d_source_o <= '0;
      d_error_o  <= 1'b0;
    end else if (accept) begin
      d_opcode_o <= resp_opcode;
      d_data_o   <= resp_data;
      d_source_o <= a_source_i;
      d_error_o  <= resp_err;
    end
  end

endmodule

// File: tb/tb_reg_bus_adapter.sv
// Self-checking bench for reg_bus_adapter: directed cases plus random traffic.
module tb_reg_bus_adapter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_valid;
  logic            a_ready;
  logic [2:0]      a_opcode;
  logic [AW-1:0]   a_address;
  logic [DW-1:0]   a_data;
  logic [DW/8-1:0] a_mask;
  logic [SW-1:0]   a_source;
  logic            d_valid;
  logic            d_ready;
  logic [2:0]      d_opcode;
  logic [DW-1:0]   d_data;
  logic [SW-1:0]   d_source;
  logic            d_error;
  logic            re;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   rdata;
  logic            error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bus_adapter #(
    .AW (AW),
    .DW (DW),
    .SW (SW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .a_valid_i   (a_valid),
    .a_ready_o   (a_ready),
    .a_opcode_i  (a_opcode),
    .a_address_i (a_address),
    .a_data_i    (a_data),
    .a_mask_i    (a_mask),
    .a_source_i  (a_source),
    .d_valid_o   (d_valid),
    .d_ready_i   (d_ready),
    .d_opcode_o  (d_opcode),
    .d_data_o    (d_data),
    .d_source_o  (d_source),
    .d_error_o   (d_error),
    .re_o        (re),
    .we_o        (we),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .be_o        (be),
    .rdata_i     (rdata),
    .error_i     (error)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  msk;
    logic [7:0]  src;
    logic [31:0] rd_val;
    logic        reg_err;
  } req_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  op;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the request rules.
  function automatic exp_t model(input req_t r);
    exp_t e;
    bit   put   = (r.op == 3'd0) || (r.op == 3'd1);
    bit   get   = (r.op == 3'd4);
    bit   bad;
    bad   = (r.adr % 4 != 0) || !(put || get) || (r.op == 3'd0 && r.msk != 4'hF)
         || (put && r.msk == 4'h0);
    e.rd  = get && !bad;
    e.wr  = put && !bad;
    e.err = bad || r.reg_err;
    e.op  = get ? 3'd1 : 3'd0;
    e.dat = !get ? 32'h0 : (e.err ? 32'hFFFF_FFFF : r.rd_val);
    return e;
  endfunction

  function automatic req_t mk(input logic [2:0] op, input logic [7:0] adr, input logic [31:0] dat,
                              input logic [3:0] msk, input logic [7:0] src,
                              input logic [31:0] rd_val, input logic reg_err);
    req_t r;
    r.op = op; r.adr = adr; r.dat = dat; r.msk = msk; r.src = src;
    r.rd_val = rd_val; r.reg_err = reg_err;
    return r;
  endfunction

  function automatic req_t rand_req(input bit legal_only);
    req_t r;
    logic [2:0] ops [8];
    ops = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd0, 3'd1, 3'd2, 3'd7};
    r.op      = legal_only ? ops[$urandom_range(0, 5)] : ops[$urandom_range(0, 7)];
    r.adr     = 8'($urandom());
    if (legal_only || $urandom_range(0, 3) != 0) r.adr[1:0] = 2'b00;
    r.dat     = $urandom();
    r.msk     = 4'($urandom());
    if (r.op == 3'd0 && (legal_only || $urandom_range(0, 3) != 0)) r.msk = 4'hF;
    if (legal_only && r.msk == 4'h0) r.msk = 4'h1;
    r.src     = 8'($urandom());
    r.rd_val  = $urandom();
    r.reg_err = legal_only ? 1'b0 : ($urandom_range(0, 7) == 0);
    return r;
  endfunction

  task automatic present(input req_t r);
    a_opcode  = r.op;
    a_address = r.adr;
    a_data    = r.dat;
    a_mask    = r.msk;
    a_source  = r.src;
    rdata     = r.rd_val;
    error     = r.reg_err;
  endtask

  task automatic chk_resp(input string tag, input req_t r, input exp_t e);
    chk({tag, ".d_valid"}, d_valid, 1'b1);
    chk({tag, ".a_ready"}, a_ready, 1'b0);
    chk({tag, ".d_opcode"}, d_opcode, e.op);
    chk({tag, ".d_data"}, d_data, e.dat);
    chk({tag, ".d_source"}, d_source, r.src);
    chk({tag, ".d_error"}, d_error, e.err);
    chk({tag, ".no_strobe"}, {re, we}, 2'b00);
  endtask

  // One full transaction with `stall` backpressure cycles before the handshake.
  task automatic do_txn(input string tag, input req_t r, input int stall);
    exp_t e = model(r);
    @(negedge clk);
    present(r);
    a_valid = 1'b1;
    d_ready = 1'b0;
    #1;
    chk({tag, ".a_ready"}, a_ready, 1'b1);
    chk({tag, ".re"}, re, e.rd);
    chk({tag, ".we"}, we, e.wr);
    if (e.rd || e.wr) begin
      chk({tag, ".addr"}, addr, {r.adr[7:2], 2'b00});
      chk({tag, ".be"}, be, r.msk);
      chk({tag, ".wdata"}, wdata, r.dat);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    chk_resp({tag, ".resp"}, r, e);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      present(rand_req(1'b1));
      a_valid = 1'b1;
      #1;
      chk_resp({tag, ".stall"}, r, e);
    end
    // Handshake cycle: a waiting request must not be accepted here.
    @(negedge clk);
    present(rand_req(1'b1));
    a_valid = 1'b1;
    d_ready = 1'b1;
    #1;
    chk({tag, ".hs_no_strobe"}, {re, we}, 2'b00);
    chk({tag, ".hs_a_ready"}, a_ready, 1'b0);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    d_ready = 1'b0;
    chk({tag, ".post_d_valid"}, d_valid, 1'b0);
    chk({tag, ".post_a_ready"}, a_ready, 1'b1);
  endtask

  initial begin
    req_t q[6];
    req_t r;
    exp_t e;

    rst_n   = 1'b0;
    a_valid = 1'b0;
    d_ready = 1'b0;
    present(mk(3'd0, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 1'b0));
    #12;
    chk("rst.a_ready", a_ready, 1'b1);
    chk("rst.d_valid", d_valid, 1'b0);
    chk("rst.d_fields", {d_opcode, d_data, d_source, d_error}, '0);
    chk("rst.strobes", {re, we}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    do_txn("write", mk(3'd0, 8'h10, 32'hDEAD_BEEF, 4'hF, 8'h03, 32'h0, 1'b0), 0);
    do_txn("read", mk(3'd4, 8'h14, 32'h0, 4'hF, 8'h07, 32'h1234_5678, 1'b0), 0);
    do_txn("get_misaligned", mk(3'd4, 8'h13, 32'h0, 4'hF, 8'h11, 32'hAAAA_5555, 1'b0), 0);
    do_txn("putfull_partmask", mk(3'd0, 8'h20, 32'h1, 4'h3, 8'h12, 32'h0, 1'b0), 0);
    do_txn("bad_opcode", mk(3'd2, 8'h24, 32'h2, 4'hF, 8'h13, 32'h0, 1'b0), 0);
    do_txn("put_zero_mask", mk(3'd1, 8'h28, 32'h3, 4'h0, 8'h14, 32'h0, 1'b0), 0);
    do_txn("reg_err_write", mk(3'd1, 8'h30, 32'h4, 4'h3, 8'h15, 32'h0, 1'b1), 0);
    do_txn("reg_err_read", mk(3'd4, 8'hFC, 32'h0, 4'hF, 8'h16, 32'h0BAD_F00D, 1'b1), 0);
    do_txn("backpressure", mk(3'd4, 8'h40, 32'h0, 4'hF, 8'h21, 32'hCAFE_0001, 1'b0), 5);

    // Back-to-back: valid held high, ready held high, accept every second cycle.
    for (int i = 0; i < 6; i++) q[i] = rand_req(1'b1);
    @(negedge clk);
    present(q[0]);
    a_valid = 1'b1;
    d_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = model(q[i]);
      #1;
      chk("b2b.accept", a_ready, 1'b1);
      chk("b2b.strobe", {re, we}, {e.rd, e.wr});
      @(negedge clk);
      if (i < 5) present(q[i + 1]);
      else a_valid = 1'b0;
      #1;
      chk_resp("b2b", q[i], e);
      @(negedge clk);
    end
    d_ready = 1'b0;

    // Reset while a response is pending.
    r = mk(3'd4, 8'h44, 32'h0, 4'hF, 8'h5A, 32'h8765_4321, 1'b0);
    e = model(r);
    @(negedge clk);
    present(r);
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    chk_resp("pre_rst", r, e);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.d_valid", d_valid, 1'b0);
    chk("midrst.a_ready", a_ready, 1'b1);
    chk("midrst.d_fields", {d_opcode, d_data, d_source, d_error}, '0);
    chk("midrst.strobes", {re, we}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst.d_valid", d_valid, 1'b0);
    chk("postrst.a_ready", a_ready, 1'b1);
    chk("postrst.strobes", {re, we}, 2'b00);

    // Random traffic, including illegal requests and register-side errors.
    for (int i = 0; i < 40; i++) begin
      do_txn("rand", rand_req(1'b0), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bus_adapter.md
# reg_bus_adapter

Bus-to-register adapter sitting directly upstream of the register file's field slices. Accepts single-beat read/write requests on a valid/ready request channel and turns each legal request into a one-cycle `re` or `we` strobe with address, write data and byte enables; `we`/`wd` feed the field slices, `rdata` is the muxed field readback. Captures read data/error and returns exactly one response per request on a valid/ready response channel, with one transaction outstanding at a time.

## Interface
Parameters:
- `AW`, 8: register byte-address width.
- `DW`, 32: data width; must be 32 (word-only register space).
- `SW`, 8: source-ID width.

Ports:
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `a_valid_i` input 1: request valid.
- `a_ready_o` output 1: request ready.
- `a_opcode_i` input 3: 0 PutFullData, 1 PutPartialData, 4 Get.
- `a_address_i` input AW: byte address.
- `a_data_i` input DW: write data.
- `a_mask_i` input DW/8: byte mask.
- `a_source_i` input SW: request ID.
- `d_valid_o` output 1: response valid.
- `d_ready_i` input 1: response ready.
- `d_opcode_o` output 3: 0 AccessAck (write), 1 AccessAckData (read).
- `d_data_o` output DW: read data.
- `d_source_o` output SW: echoed request ID.
- `d_error_o` output 1: error response.
- `re_o` output 1: read strobe to register file.
- `we_o` output 1: write strobe to register file.
- `addr_o` output AW: word-aligned register address.
- `wdata_o` output DW: write data.
- `be_o` output DW/8: byte enables.
- `rdata_i` input DW: register readback, valid in the `re_o` cycle.
- `error_i` input 1: register-side error (unmapped address), valid in the `re_o`/`we_o` cycle.

## Operation
- Two states: IDLE (no response pending), RESP (response held on `d_*`).
- `a_ready_o` = 1 in IDLE, 0 in RESP. Accept = `a_valid_i & a_ready_o`.
- Request error (`req_err`) if any: `a_address_i[1:0] != 0`; opcode not in {0,1,4}; PutFullData with `a_mask_i != '1`; write with `a_mask_i == 0`.
- On accept with no `req_err`: Get -> `re_o`=1; Put* -> `we_o`=1; strobe is combinational, same cycle, exactly one cycle. `addr_o` = `{a_address_i[AW-1:2], 2'b00}`, `wdata_o` = `a_data_i`, `be_o` = `a_mask_i`, driven from the request inputs.
- On accept with `req_err`: no strobe.
- Accept moves IDLE -> RESP and registers: `d_opcode_o` (1 for Get, else 0; 0 for bad opcode), `d_source_o` = `a_source_i`, `d_error_o` = `req_err | error_i`, `d_data_o` = `rdata_i` for error-free Get, all-ones for errored Get, 0 for writes.
- RESP: `d_valid_o`=1, `d_*` stable until `d_valid_o & d_ready_i`; then -> IDLE.
- No request is accepted in the cycle the response handshakes (`a_ready_o` derives only from registered state).

## Timing
- Reset values: state IDLE, `a_ready_o`=1, `d_valid_o`=0, `d_opcode_o`=0, `d_data_o`=0, `d_source_o`=0, `d_error_o`=0, `re_o`=`we_o`=0.
- Request accepted cycle N -> strobe cycle N -> `d_valid_o` cycle N+1.
- `d_ready_i` high at N+1 -> `a_ready_o` high at N+2. Peak throughput one transaction per 2 cycles.
- `d_ready_i` low: response held indefinitely, `a_ready_o` held 0, no strobes.
- Reset asserted mid-transaction: pending response dropped, all outputs to reset values immediately.

## Structure
- Package `reg_bus_pkg`: opcode typedefs (`a_op_e`: PutFullData=0, PutPartialData=1, Get=4; `d_op_e`: AccessAck=0, AccessAckData=1).
- Sub-module `reg_bus_err`: combinational `req_err` checker (opcode, alignment, mask).
- State is a single pending flag plus response registers; no FIFO.

## Test plan
- Write: Put opcode 0, address 0x10, data 0xDEADBEEF, mask 0xF, source 0x3 -> `we_o`=1 one cycle, `addr_o`=0x10, `be_o`=0xF; next cycle `d_valid_o`=1, opcode 0, source 0x3, error 0.
- Read: Get address 0x14, `rdata_i`=0x12345678 -> `re_o`=1 one cycle; response opcode 1, data 0x12345678, error 0.
- Errors: Get at 0x13 -> no strobe, d_error 1, data 0xFFFFFFFF; PutFullData mask 0x3 -> no `we_o`, d_error 1; opcode 2 -> error; `error_i`=1 during a `we_o` -> d_error 1.
- Backpressure: `d_ready_i` low 5 cycles -> `d_*` stable, `a_ready_o`=0, no strobes; release -> next request accepted the following cycle.
- Back-to-back: continuous `a_valid_i`, `d_ready_i`=1 -> accepts every 2nd cycle, responses in order with matching sources.
- Reset with response pending -> `d_valid_o`=0, `a_ready_o`=1 after reset release, no spurious strobe.
